imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: takes a byte stream from the host link (UART receiver or debug port) and assembles it into 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive word indices, starting at index 0.
- Holds the CPU in reset until a complete image has been written, so fetch at pc[31:2] only ever sees loaded code.

Parameters:
- MEM_SIZE, 8192, instruction memory depth in 32-bit words (32 KB).
- ADDR_W, 13, word-index width; must equal clog2(MEM_SIZE).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle. A byte transfers when rx_valid && rx_ready at a rising edge.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_waddr  output  ADDR_W  word index to write; equals the byte address >> 2.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  CPU reset request; high in every state except DONE.
- busy  output  1  high in HDR, DATA and WRITE.
- done  output  1  high in DONE.
- overflow_err  output  1  sticky; image exceeded MEM_SIZE words.

Behaviour:
- Stream format:
  - 4-byte little-endian word count N.
  - Followed by N×4 data bytes.
  - Each group of 4 bytes forms one word, little-endian: first byte goes to [7:0], fourth byte to [31:24].
- States: IDLE, HDR, DATA, WRITE, DONE.
- Reset:
  - state=IDLE, byte counter=0, word index=0, N=0.
  - rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, overflow_err=0.
- IDLE:
  - rx_ready=0; all bytes are ignored.
  - start → HDR; clears byte counter, word index and overflow_err.
- HDR:
  - rx_ready=1. Each accepted byte shifts into N, little-endian.
  - After the 4th byte: if N==0 → DONE, else → DATA.
- DATA:
  - rx_ready=1. Each accepted byte shifts into the word assembly register; the byte counter increments modulo 4.
  - 4th byte accepted at edge t → WRITE, entered at edge t.
- WRITE (exactly one cycle; rx_ready=0):
  - If word index < MEM_SIZE: mem_we=1, mem_waddr=word index, mem_wdata=assembled word.
  - Otherwise: mem_we=0 and overflow_err is set. The word is consumed but discarded.
  - Word index increments. If the incremented index == N → DONE, else → DATA.
- Timing: mem_we is high during cycle t+1 after the edge that accepted the 4th byte. rx_ready is high again from cycle t+2.
- DONE:
  - cpu_hold=0, done=1, rx_ready=0.
  - Stays until reset or start; start → HDR (reload) and cpu_hold rises the next cycle.
- start in HDR, DATA or WRITE is ignored.
- rx_valid high while rx_ready is low: no transfer, and no byte is lost from the loader's point of view. The sender must hold the byte.
- Word index is 32-bit internally. mem_waddr carries its low ADDR_W bits only when writing; overflow is detected on the full 32-bit index.
- Reset mid-load: returns to IDLE immediately and cpu_hold=1. Words already written stay in memory; the partial word in the assembly register is dropped.
- mem_we is never high outside WRITE; at most one write per 4 data bytes.

Test Plan:
- Load N=2 (bytes 02 00 00 00, 13 00 00 00, 93 00 10 00) → writes 0x00000013 at index 0, then 0x00100093 at index 1. Each mem_we is high exactly one cycle after the 4th byte. done=1, cpu_hold falls after the second write, overflow_err=0.
- N=0 header (00 00 00 00) → DONE straight after the header, no mem_we pulses, cpu_hold=0.
- Random rx_valid gaps, including rx_valid high during WRITE, with N=3 → exactly 12 data bytes consumed, 3 writes at indices 0,1,2 with the correct words, no byte duplicated or skipped.
- MEM_SIZE=4, N=6 → 4 writes at indices 0..3, the remaining 8 bytes consumed with no mem_we, overflow_err=1 with done=1.
- Assert rst after 5 data bytes of an N=4 load → next cycle state=IDLE, cpu_hold=1, busy=0, mem_we=0. A following start plus a full N=1 load writes index 0 correctly.
- start pulse in DATA → ignored (byte count and word index unchanged). start in DONE → cpu_hold=1 next cycle and a fresh header is expected.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: turns a host byte stream (4-byte LE word count, then LE words)
// into consecutive instruction-memory writes and keeps the CPU in reset
// until the whole image is in place.
module imem_loader #(
   parameter int MEM_SIZE = 8192,
   parameter int ADDR_W   = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_waddr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              overflow_err_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Word index is compared on all 32 bits so an oversized image is caught
   // even once the low address bits have wrapped.
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

   state_t              state_q;
   logic [1:0]          bcnt_q;
   logic [31:0]         widx_q;
   logic [31:0]         n_q;
   logic [23:0]         asm_q;     // first three bytes of the word in flight
   logic                rx_ready_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_waddr_q;
   logic [31:0]         mem_wdata_q;
   logic                cpu_hold_q;
   logic                busy_q;
   logic                done_q;
   logic                ovf_q;

   logic                accept;
   logic [31:0]         n_d;
   logic [31:0]         word_d;
   logic [31:0]         widx_d;

   // A byte moves only while we advertise ready; new bytes enter at the top
   // so after four shifts the first byte sits in bits [7:0].
   assign accept = rx_valid_i && rx_ready_q;
   assign n_d    = {rx_data_i, n_q[31:8]};
   assign word_d = {rx_data_i, asm_q};
   assign widx_d = widx_q + 32'd1;

   // Loader FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bcnt_q      <= 2'd0;
         widx_q      <= 32'd0;
         n_q         <= 32'd0;
         asm_q       <= 24'd0;
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= 32'd0;
         cpu_hold_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q    <= S_HDR;
                  bcnt_q     <= 2'd0;
                  widx_q     <= 32'd0;
                  ovf_q      <= 1'b0;
                  rx_ready_q <= 1'b1;
                  cpu_hold_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            S_HDR: begin
               if (accept) begin
                  n_q    <= n_d;
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     if (n_d == 32'd0) begin
                        state_q    <= S_DONE;
                        rx_ready_q <= 1'b0;
                        cpu_hold_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                     end else begin
                        state_q <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  asm_q  <= word_d[31:8];
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     // Strobe is set here so it is high for the WRITE cycle.
                     state_q    <= S_WRITE;
                     rx_ready_q <= 1'b0;
                     if (widx_q < MEM_LIMIT) begin
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= widx_q[ADDR_W-1:0];
                        mem_wdata_q <= word_d;
                     end else begin
                        ovf_q <= 1'b1;
                     end
                  end
               end
            end
            S_WRITE: begin
               widx_q <= widx_d;
               if (widx_d == n_q) begin
                  state_q    <= S_DONE;
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  state_q    <= S_DATA;
                  rx_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               rx_ready_q <= 1'b0;
               cpu_hold_q <= 1'b1;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign rx_ready_o     = rx_ready_q;
   assign mem_we_o       = mem_we_q;
   assign mem_waddr_o    = mem_waddr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign cpu_hold_o     = cpu_hold_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives randomized image loads into a small (4-word)
// loader and checks writes, byte consumption and status against a model.
module tb_imem_loader;

   localparam int MEM_SIZE = 4;
   localparam int ADDR_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_waddr_o;
   logic [31:0]       mem_wdata_o;
   logic              cpu_hold_o;
   logic              busy_o;
   logic              done_o;
   logic              overflow_err_o;

   imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start),
      .rx_data_i      (rx_data),
      .rx_valid_i     (rx_valid),
      .rx_ready_o     (rx_ready_o),
      .mem_we_o       (mem_we_o),
      .mem_waddr_o    (mem_waddr_o),
      .mem_wdata_o    (mem_wdata_o),
      .cpu_hold_o     (cpu_hold_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .overflow_err_o (overflow_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          lag;
      int          nacc;
   } wr_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          acc_edge = -10;
   logic [7:0]  acc_q[$];
   wr_t         wr_q[$];
   logic [31:0] img[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe the link and the write port between edges.
   always @(negedge clk) begin
      if (rx_valid && rx_ready_o) begin
         acc_q.push_back(rx_data);
         acc_edge = cyc + 1;
      end
      if (mem_we_o)
         wr_q.push_back('{32'(mem_waddr_o), mem_wdata_o, cyc - acc_edge, acc_q.size()});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      forever begin
         @(negedge clk);
         if (rx_ready_o) begin
            @(posedge clk); #1;
            break;
         end
         t++;
         if (t > 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      rx_valid = 1'b0;
   endtask

   // One full load of img[] with header n; expectations come from the
   // stream rules: words below MEM_SIZE land at their index, the rest
   // are swallowed and flag overflow.
   task automatic run_load(input int n, input bit gaps, input int mid_start);
      logic [7:0] exp_b[$];
      logic [31:0] nn;
      int t;
      int n_wr;
      nn = 32'(n);
      for (int i = 0; i < 4; i++) exp_b.push_back(nn[8*i +: 8]);
      for (int w = 0; w < n; w++)
         for (int i = 0; i < 4; i++) exp_b.push_back(img[w][8*i +: 8]);

      // Bytes offered while idle/done must be left alone.
      acc_q.delete();
      wr_q.delete();
      rx_valid = 1'b1;
      repeat (3) begin
         rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      chk("idle_accepts", 32'(acc_q.size()), 32'd0);

      pulse_start();
      chk("start_busy", 32'(busy_o), 32'd1);
      chk("start_hold", 32'(cpu_hold_o), 32'd1);
      chk("start_done", 32'(done_o), 32'd0);
      chk("start_ready", 32'(rx_ready_o), 32'd1);

      for (int k = 0; k < exp_b.size(); k++) begin
         if (mid_start >= 0 && k == 4 + mid_start) pulse_start();
         send_byte(exp_b[k], gaps);
      end

      t = 0;
      while (!done_o && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done", 32'(done_o), 32'd1);
      chk("hold_released", 32'(cpu_hold_o), 32'd0);
      chk("busy_end", 32'(busy_o), 32'd0);
      chk("ready_end", 32'(rx_ready_o), 32'd0);
      chk("overflow", 32'(overflow_err_o), 32'(n > MEM_SIZE));

      chk("bytes_consumed", 32'(acc_q.size()), 32'(exp_b.size()));
      for (int k = 0; k < exp_b.size() && k < acc_q.size(); k++)
         chk($sformatf("byte%0d", k), 32'(acc_q[k]), 32'(exp_b[k]));

      n_wr = (n < MEM_SIZE) ? n : MEM_SIZE;
      chk("write_count", 32'(wr_q.size()), 32'(n_wr));
      for (int i = 0; i < n_wr && i < wr_q.size(); i++) begin
         chk($sformatf("waddr%0d", i), wr_q[i].a, 32'(i));
         chk($sformatf("wdata%0d", i), wr_q[i].d, img[i]);
         chk($sformatf("wlag%0d", i), 32'(wr_q[i].lag), 32'd0);
         chk($sformatf("wbytes%0d", i), 32'(wr_q[i].nacc), 32'(8 + 4 * i));
      end
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", 32'(rx_ready_o), 32'd0);
      chk("rst_we", 32'(mem_we_o), 32'd0);
      chk("rst_waddr", 32'(mem_waddr_o), 32'd0);
      chk("rst_wdata", mem_wdata_o, 32'd0);
      chk("rst_hold", 32'(cpu_hold_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_ovf", 32'(overflow_err_o), 32'd0);

      // Two-instruction image, back to back.
      img = '{32'h00000013, 32'h00100093};
      run_load(2, 1'b0, -1);
      $display("load n=2 writes=%0d", wr_q.size());

      // Empty image straight from DONE (reload path).
      img.delete();
      run_load(0, 1'b0, -1);
      $display("load n=0 writes=%0d", wr_q.size());

      // Gappy sender, start pulse mid-word must be ignored.
      img = '{32'hdeadbeef, 32'h12345678, 32'h0badf00d};
      run_load(3, 1'b1, 2);
      $display("load n=3 gaps+start writes=%0d", wr_q.size());

      // Oversized image: N=6 into 4 words.
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back($urandom);
      run_load(6, 1'b1, -1);
      $display("load n=6 overflow=%0d writes=%0d", overflow_err_o, wr_q.size());

      // Reset after 5 data bytes of an N=4 load.
      acc_q.delete();
      wr_q.delete();
      img = '{32'ha1b2c3d4, 32'h55667788};
      pulse_start();
      send_byte(8'h04, 1'b0);
      repeat (3) send_byte(8'h00, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(img[0][8*i +: 8], 1'b0);
      send_byte(img[1][7:0], 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_hold", 32'(cpu_hold_o), 32'd1);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_we", 32'(mem_we_o), 32'd0);
      chk("mid_rst_done", 32'(done_o), 32'd0);
      chk("mid_rst_ready", 32'(rx_ready_o), 32'd0);
      chk("mid_rst_writes", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) chk("mid_rst_wdata", wr_q[0].d, 32'ha1b2c3d4);
      $display("reset mid-load writes=%0d", wr_q.size());
      img = '{32'hcafe0001};
      run_load(1, 1'b0, -1);
      $display("load n=1 after reset writes=%0d", wr_q.size());

      // Random images, some overflowing.
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(0, 6);
         img.delete();
         for (int i = 0; i < n; i++) img.push_back($urandom);
         run_load(n, 1'b1, ($urandom_range(0, 1) == 1) ? 5 : -1);
         $display("load random n=%0d writes=%0d ovf=%0d", n, wr_q.size(), overflow_err_o);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
